// File: rtl/hd6309_pkg.sv
// Shared types and helpers for the HD6309 DMA bus arbiter.
package hd6309_pkg;

  localparam int ARB_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_WAIT = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  // Modular add on requester indices; the caller guarantees p < n and off < n.
  function automatic logic [ARB_ID_W-1:0] wrap_add(
    input logic [ARB_ID_W-1:0] p,
    input int                  off,
    input int                  n
  );
    int s;
    s = int'(p) + off;
    if (s >= n) s = s - n;
    return ARB_ID_W'(s);
  endfunction

endpackage

// File: rtl/hd6309_rr_pick.sv
// Combinational round-robin encoder: first set request at or after ptr, wrapping.
module hd6309_rr_pick
  import hd6309_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]     req,
  input  logic [ARB_ID_W-1:0] ptr,
  output logic                valid,
  output logic [ARB_ID_W-1:0] win
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  // Scan from the farthest offset down so the nearest set request wins last.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (|(req & (ONE << wrap_add(ptr, i, NREQ)))) begin
        valid = 1'b1;
        win   = wrap_add(ptr, i, NREQ);
      end
    end
  end

endmodule

// File: rtl/hd6309_dma_arbiter.sv
// Round-robin DMA bus arbiter for the HD6309 bus, stepped by falling edges of E.
// Optional burst limit enabled by defining ARB_BURST_LIMIT_EN.
module hd6309_dma_arbiter
  import hd6309_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 14,
  parameter int CNT_W     = 4
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                E,
  input  logic                BA,
  input  logic                BS,
  input  logic [NREQ-1:0]     REQ,
  output logic                nDMABREQ,
  output logic [NREQ-1:0]     GNT,
  output logic [ARB_ID_W-1:0] GNT_ID,
  output logic                BUSY
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 15 ||
      (1 << CNT_W) <= MAX_BURST) begin : g_param_check
    $error("hd6309_dma_arbiter: parameter out of range");
  end

  arb_state_t          state;
  logic                e_d;
  logic                tick;
  logic                rel_seen;
  logic [ARB_ID_W-1:0] rr_ptr;
  logic [CNT_W-1:0]    burst_cnt;
  logic                pick_valid;
  logic [ARB_ID_W-1:0] pick_id;
  logic                req_held;
  logic                limit_hit;
  logic                release_now;

  assign tick = e_d & ~E;

  hd6309_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (REQ),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .win   (pick_id)
  );

  // GNT is one-hot on the current master, so masking REQ with it reads that master's request.
  assign req_held = |(REQ & GNT);

`ifdef ARB_BURST_LIMIT_EN
  assign limit_hit = (burst_cnt == CNT_W'(MAX_BURST - 1));
`else
  assign limit_hit = 1'b0;
`endif

  assign release_now = ~req_held | limit_hit;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      e_d       <= 1'b0;
      state     <= IDLE;
      nDMABREQ  <= 1'b1;
      GNT       <= '0;
      GNT_ID    <= '0;
      BUSY      <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rel_seen  <= 1'b0;
    end else begin
      e_d <= E;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (|REQ) begin
              state    <= REQ_WAIT;
              nDMABREQ <= 1'b0;
              BUSY     <= 1'b1;
            end
          end

          REQ_WAIT: begin
            if (BA && BS) begin
              if (pick_valid) begin
                state     <= GRANT;
                GNT       <= ONE << pick_id;
                GNT_ID    <= pick_id;
                burst_cnt <= '0;
              end else begin
                state    <= RELEASE;
                nDMABREQ <= 1'b1;
                rel_seen <= 1'b0;
              end
            end
          end

          GRANT: begin
            if (burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
            if (release_now) begin
              state    <= RELEASE;
              GNT      <= '0;
              nDMABREQ <= 1'b1;
              rr_ptr   <= wrap_add(GNT_ID, 1, NREQ);
              rel_seen <= 1'b0;
            end
          end

          RELEASE: begin
            // Hand the CPU at least one full bus cycle after it retakes the bus.
            if (rel_seen) begin
              state    <= IDLE;
              BUSY     <= 1'b0;
              rel_seen <= 1'b0;
            end else if (!BA) begin
              rel_seen <= 1'b1;
            end
          end

          default: begin
            state    <= IDLE;
            GNT      <= '0;
            nDMABREQ <= 1'b1;
            BUSY     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hd6309_dma_arbiter.sv
// Directed scoreboard bench for hd6309_dma_arbiter (NREQ=4).
module tb_hd6309_dma_arbiter;

  logic       CLK = 1'b0;
  logic       nRESET;
  logic       E;
  logic       BA;
  logic       BS;
  logic [3:0] REQ;
  logic       nDMABREQ;
  logic [3:0] GNT;
  logic [2:0] GNT_ID;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [2:0] id;
    logic       ndma;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  hd6309_dma_arbiter #(
    .NREQ      (4),
    .MAX_BURST (14),
    .CNT_W     (4)
  ) dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .E        (E),
    .BA       (BA),
    .BS       (BS),
    .REQ      (REQ),
    .nDMABREQ (nDMABREQ),
    .GNT      (GNT),
    .GNT_ID   (GNT_ID),
    .BUSY     (BUSY)
  );

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [2:0] i, input logic nd, input logic b);
    exp_t e;
    e.gnt  = g;
    e.id   = i;
    e.ndma = nd;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = sb.pop_front();
    cmp({tag, ".gnt"},  8'(GNT),      8'(e.gnt));
    cmp({tag, ".id"},   8'(GNT_ID),   8'(e.id));
    cmp({tag, ".ndma"}, 8'(nDMABREQ), 8'(e.ndma));
    cmp({tag, ".busy"}, 8'(BUSY),     8'(e.busy));
  endtask

  // One E falling edge; returns at the negedge after the edge that saw the tick.
  task automatic e_tick();
    @(negedge CLK) E = 1'b1;
    @(negedge CLK) E = 1'b0;
    @(negedge CLK);
  endtask

  task automatic step(input string tag, input logic [3:0] g, input logic [2:0] i,
                      input logic nd, input logic b);
    push(g, i, nd, b);
    e_tick();
    pop_check(tag);
  endtask

  // Independent tick model for the grant-qualification property.
  logic       e_d_m;
  logic       qual_q;
  logic [3:0] gnt_prev = 4'b0;

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      e_d_m  <= 1'b0;
      qual_q <= 1'b0;
    end else begin
      e_d_m  <= E;
      qual_q <= e_d_m & ~E & BA & BS;
    end
  end

  always @(negedge CLK) begin
    if (nRESET === 1'b1) begin
      cmp("gnt_onehot0", 8'($onehot0(GNT)), 8'd1);
      cmp("gnt_implies_breq", 8'((GNT == 4'b0) || (nDMABREQ == 1'b0)), 8'd1);
      cmp("gnt_rise_qualified", 8'(!((GNT != 4'b0) && (gnt_prev == 4'b0)) || qual_q), 8'd1);
    end
    gnt_prev = GNT;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [2:0] prev_id;

    nRESET = 1'b0;
    E      = 1'b0;
    BA     = 1'b0;
    BS     = 1'b0;
    REQ    = 4'b0;
    repeat (3) @(negedge CLK);
    push(4'b0, 3'd0, 1'b1, 1'b0);
    pop_check("reset");
    nRESET = 1'b1;

    // Single master
    REQ = 4'b0010;
    step("single_reqwait", 4'b0, 3'd0, 1'b0, 1'b1);
    step("single_ba_low",  4'b0, 3'd0, 1'b0, 1'b1);
    BA = 1'b1; BS = 1'b1;
    step("single_grant",   4'b0010, 3'd1, 1'b0, 1'b1);
    step("single_hold",    4'b0010, 3'd1, 1'b0, 1'b1);
    REQ = 4'b0;
    step("single_drop",    4'b0, 3'd1, 1'b1, 1'b1);
    BA = 1'b0; BS = 1'b0;
    step("single_rel_ba0", 4'b0, 3'd1, 1'b1, 1'b1);
    step("single_idle",    4'b0, 3'd1, 1'b1, 1'b0);
    step("single_stay",    4'b0, 3'd1, 1'b1, 1'b0);

    // Reset during a grant
    REQ = 4'b0001;
    step("rst_reqwait", 4'b0, 3'd1, 1'b0, 1'b1);
    BA = 1'b1; BS = 1'b1;
    step("rst_grant", 4'b0001, 3'd0, 1'b0, 1'b1);
    @(negedge CLK) nRESET = 1'b0;
    #1;
    push(4'b0, 3'd0, 1'b1, 1'b0);
    pop_check("rst_async");
    REQ = 4'b0; BA = 1'b0; BS = 1'b0;
    @(negedge CLK) nRESET = 1'b1;
    step("rst_idle1", 4'b0, 3'd0, 1'b1, 1'b0);
    step("rst_idle2", 4'b0, 3'd0, 1'b1, 1'b0);

    // Round-robin with all requests pending
    REQ = 4'hF;
    prev_id = 3'd0;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      step($sformatf("rr%0d_reqwait", k), 4'b0, prev_id, 1'b0, 1'b1);
      BA = 1'b1; BS = 1'b1;
      step($sformatf("rr%0d_grant", k), 4'(1 << w), 3'(w), 1'b0, 1'b1);
      REQ = 4'hF & ~4'(1 << w);
      step($sformatf("rr%0d_release", k), 4'b0, 3'(w), 1'b1, 1'b1);
      REQ = 4'hF; BA = 1'b0; BS = 1'b0;
      step($sformatf("rr%0d_rel_ba0", k), 4'b0, 3'(w), 1'b1, 1'b1);
      step($sformatf("rr%0d_idle", k), 4'b0, 3'(w), 1'b1, 1'b0);
      prev_id = 3'(w);
    end

    // Burst behaviour on a single held request
    REQ = 4'b0001;
    step("burst_reqwait", 4'b0, 3'd0, 1'b0, 1'b1);
    BA = 1'b1; BS = 1'b1;
    step("burst_grant", 4'b0001, 3'd0, 1'b0, 1'b1);
`ifdef ARB_BURST_LIMIT_EN
    for (int k = 1; k < 14; k++)
      step($sformatf("burst_hold%0d", k), 4'b0001, 3'd0, 1'b0, 1'b1);
    step("burst_limit", 4'b0, 3'd0, 1'b1, 1'b1);
    REQ = 4'b0;
`else
    for (int k = 1; k <= 100; k++)
      step($sformatf("burst_hold%0d", k), 4'b0001, 3'd0, 1'b0, 1'b1);
    REQ = 4'b0;
    step("burst_drop", 4'b0, 3'd0, 1'b1, 1'b1);
`endif
    BA = 1'b0; BS = 1'b0;
    step("burst_rel_ba0", 4'b0, 3'd0, 1'b1, 1'b1);
    step("burst_idle",    4'b0, 3'd0, 1'b1, 1'b0);

    // Request withdrawn before the grant
    REQ = 4'b0100;
    step("abort_reqwait", 4'b0, 3'd0, 1'b0, 1'b1);
    REQ = 4'b0; BA = 1'b1; BS = 1'b1;
    step("abort_release", 4'b0, 3'd0, 1'b1, 1'b1);
    step("abort_ba_high", 4'b0, 3'd0, 1'b1, 1'b1);
    BA = 1'b0; BS = 1'b0;
    step("abort_rel_ba0", 4'b0, 3'd0, 1'b1, 1'b1);
    step("abort_idle",    4'b0, 3'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
